blinky_one_second: RTL and testbench

- Free-running LED blinker for the 12 MHz board clock.
- A prescaler derives a 256 Hz tick strobe from CLK.
- A tick counter toggles YELLOW_LED once per second, giving a 0.5 Hz square wave with a 2 s period and 50% duty.
- Top-level leaf block that drives the board's yellow LED pin directly.

---
 rtl/blinky_one_second.sv | 88 ++++++++
 tb/tb_blinky_one_second.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/blinky_one_second.sv
`default_nettype none
// ============================================================================
// Module      : blinky_one_second
// Description : Free-running yellow LED blinker. A prescaler divides CLK down
//               to a tick strobe, and a tick counter toggles the LED once per
//               TOGGLE_TICKS ticks (1 s, 0.5 Hz square wave by default).
//               Optional debug strobe output TICK_OUT via BLINKY_TICK_OUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module blinky_one_second #(
  parameter int CLK_FREQ_HZ  = 12000000,
  parameter int TICK_HZ      = 256,
  parameter int TOGGLE_TICKS = 256
) (
  input  logic CLK,
  input  logic RST_N,
`ifdef BLINKY_TICK_OUT_EN
  output logic TICK_OUT,
`endif
  output logic YELLOW_LED
);

  localparam int c_PRESC_DIV = (TICK_HZ > 0) ? (CLK_FREQ_HZ / TICK_HZ) : 0;
  localparam int c_PRESC_REM = (TICK_HZ > 0) ? (CLK_FREQ_HZ % TICK_HZ) : 1;
  localparam int c_PRESC_W   = (c_PRESC_DIV > 2) ? $clog2(c_PRESC_DIV) : 1;
  localparam int c_TICK_W    = (TOGGLE_TICKS > 2) ? $clog2(TOGGLE_TICKS) : 1;

  localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(c_PRESC_DIV - 1);
  localparam logic [c_TICK_W-1:0]  c_TICK_LAST  = c_TICK_W'(TOGGLE_TICKS - 1);

  // Reject configurations whose divide is inexact or too small to count.
  if ((TICK_HZ <= 0) || (c_PRESC_REM != 0) || (c_PRESC_DIV < 2)) begin : g_bad_presc
    $error("blinky_one_second: CLK_FREQ_HZ/TICK_HZ must divide exactly and be >= 2");
  end
  if (TOGGLE_TICKS < 1) begin : g_bad_toggle
    $error("blinky_one_second: TOGGLE_TICKS must be >= 1");
  end

  logic [c_PRESC_W-1:0] r_presc_cnt;
  logic [c_TICK_W-1:0]  r_tick_cnt;
  logic                 r_led;
  logic                 w_tick;
  logic                 w_tick_wrap;

  assign w_tick      = (r_presc_cnt == c_PRESC_LAST);
  assign w_tick_wrap = (r_tick_cnt == c_TICK_LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_presc_cnt <= '0;
      r_tick_cnt  <= '0;
      r_led       <= 1'b0;
    end else begin
      if (w_tick) begin
        r_presc_cnt <= '0;
      end else begin
        r_presc_cnt <= r_presc_cnt + 1'b1;
      end

      if (w_tick) begin
        if (w_tick_wrap) begin
          r_tick_cnt <= '0;
          r_led      <= ~r_led;
        end else begin
          r_tick_cnt <= r_tick_cnt + 1'b1;
        end
      end
    end
  end

  assign YELLOW_LED = r_led;

`ifdef BLINKY_TICK_OUT_EN
  logic r_tick_out;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_tick_out <= 1'b0;
    end else begin
      r_tick_out <= w_tick;
    end
  end

  assign TICK_OUT = r_tick_out;
`endif

endmodule
`default_nettype wire

// File: tb/tb_blinky_one_second.sv
`default_nettype none
// ============================================================================
// Module      : tb_blinky_one_second
// Description : Self-checking bench for blinky_one_second in a small config
//               (PRESC_DIV=10, TOGGLE_TICKS=4) against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_blinky_one_second;

  localparam int c_CLK_FREQ  = 40;
  localparam int c_TICK_HZ   = 4;
  localparam int c_TOGGLE    = 4;
  localparam int c_PRESC     = c_CLK_FREQ / c_TICK_HZ;
  localparam int c_HALF_PER  = c_PRESC * c_TOGGLE;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic YELLOW_LED;
`ifdef BLINKY_TICK_OUT_EN
  logic TICK_OUT;
`endif

  int checks = 0;
  int failures = 0;
  int edges = 0;  // rising edges since the last reset release
  bit in_reset = 1'b1;

  always #5 CLK = ~CLK;

  blinky_one_second #(
    .CLK_FREQ_HZ (c_CLK_FREQ),
    .TICK_HZ     (c_TICK_HZ),
    .TOGGLE_TICKS(c_TOGGLE)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
`ifdef BLINKY_TICK_OUT_EN
    .TICK_OUT  (TICK_OUT),
`endif
    .YELLOW_LED(YELLOW_LED)
  );

  typedef struct {
    int edge_num;
    bit exp_led;
  } vec_t;

  function automatic bit model_led(int e, bit rst);
    if (rst) return 1'b0;
    return ((e / c_HALF_PER) % 2) == 1;
  endfunction

  function automatic bit model_tick(int e, bit rst);
    if (rst) return 1'b0;
    return (e > 0) && ((e % c_PRESC) == 0);
  endfunction

  task automatic check_bit(string name, bit act, bit exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d actual=%b expected=%b", name, edges, act, exp);
    end
  endtask

  task automatic check_model();
    check_bit("led_model", YELLOW_LED, model_led(edges, in_reset));
`ifdef BLINKY_TICK_OUT_EN
    check_bit("tick_model", TICK_OUT, model_tick(edges, in_reset));
`endif
  endtask

  task automatic step_check(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
      if (!in_reset) edges++;
      check_model();
    end
  endtask

  task automatic release_reset();
    @(negedge CLK);
    RST_N = 1'b1;
    in_reset = 1'b0;
    edges = 0;
  endtask

  // Drop RST_N between clock edges and confirm the LED clears immediately.
  task automatic async_reset(int hold_cycles);
    #($urandom_range(1, 3));
    RST_N = 1'b0;
    in_reset = 1'b1;
    #1;
    check_bit("async_rst_led", YELLOW_LED, 1'b0);
    for (int i = 0; i < hold_cycles; i++) @(negedge CLK);
    release_reset();
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{edge_num: 1,   exp_led: 1'b0};
    vecs[1] = '{edge_num: 39,  exp_led: 1'b0};
    vecs[2] = '{edge_num: 40,  exp_led: 1'b1};
    vecs[3] = '{edge_num: 79,  exp_led: 1'b1};
    vecs[4] = '{edge_num: 80,  exp_led: 1'b0};
    vecs[5] = '{edge_num: 119, exp_led: 1'b0};
    vecs[6] = '{edge_num: 120, exp_led: 1'b1};

    // Reset held for 10 cycles with the clock running.
    #1;
    check_bit("reset_state", YELLOW_LED, 1'b0);
    step_check(10);
    release_reset();

    // Table of LED edge boundaries after release.
    for (int v = 0; v < 7; v++) begin
      step_check(vecs[v].edge_num - edges);
      check_bit("table_led", YELLOW_LED, vecs[v].exp_led);
    end

    // Mid-period reset at edge 65 while LED is high.
    step_check(c_HALF_PER * 2);
    async_reset(0);
    step_check(65);
    check_bit("pre_pulse_led", YELLOW_LED, 1'b1);
    async_reset(1);
    step_check(c_HALF_PER - 1);
    check_bit("after_pulse_low", YELLOW_LED, 1'b0);
    step_check(1);
    check_bit("after_pulse_rise", YELLOW_LED, 1'b1);

    // Randomized run lengths and reset pulses against the model.
    for (int r = 0; r < 12; r++) begin
      step_check(int'($urandom_range(1, 250)));
      async_reset(int'($urandom_range(0, 4)));
    end
    step_check(3 * c_HALF_PER);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
